// File: rtl/scroll_pos_gen.sv
// Per-frame scroll offset generator: owns horizontal scroll position, speed ramp,
// travelled distance and the IDLE/RUN/CRASH game state for the background scroller.
module scroll_pos_gen #(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned POS_Y       = 0,
    parameter int unsigned SPEED_INIT  = 2,
    parameter int unsigned SPEED_MAX   = 8,
    parameter int unsigned RAMP_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        crash,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic [3:0]  speed,
    output logic [15:0] distance,
    output logic        running,
    output logic        crashed,
    output logic        wrapped
);

    localparam int unsigned RampW = $clog2(RAMP_FRAMES) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StCrash} state_e;

    state_e             state_q, state_d;
    logic [10:0]        pos_q, pos_d;
    logic [3:0]         speed_q, speed_d;
    logic [RampW-1:0]   ramp_q, ramp_d;
    logic [15:0]        dist_q, dist_d;
    logic               wrap_q, wrap_d;

    // Widened operands so the wrap-around subtraction never underflows.
    logic [11:0]        pos_ext, speed_ext;
    logic [16:0]        dist_sum;

    assign pos_ext   = {1'b0, pos_q};
    assign speed_ext = {8'd0, speed_q};
    assign dist_sum  = {1'b0, dist_q} + {13'd0, speed_q};

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        speed_d = speed_q;
        ramp_d  = ramp_q;
        dist_d  = dist_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                // crash wins over a same-cycle frame_tick, which is dropped
                if (crash) begin
                    state_d = StCrash;
                end else if (frame_tick) begin
                    if (pos_ext >= speed_ext) begin
                        pos_d = 11'(pos_ext - speed_ext);
                    end else begin
                        pos_d  = 11'(pos_ext + 12'(WIDTH) - speed_ext);
                        wrap_d = 1'b1;
                    end
                    dist_d = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
                    if (ramp_q == RampW'(RAMP_FRAMES - 1)) begin
                        ramp_d  = '0;
                        speed_d = (speed_q >= 4'(SPEED_MAX)) ? 4'(SPEED_MAX) : speed_q + 4'd1;
                    end else begin
                        ramp_d = ramp_q + RampW'(1);
                    end
                end
            end
            StCrash: begin
                if (start) begin
                    state_d = StRun;
                    pos_d   = '0;
                    speed_d = 4'(SPEED_INIT);
                    ramp_d  = '0;
                    dist_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pos_q   <= '0;
            speed_q <= 4'(SPEED_INIT);
            ramp_q  <= '0;
            dist_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            speed_q <= speed_d;
            ramp_q  <= ramp_d;
            dist_q  <= dist_d;
            wrap_q  <= wrap_d;
        end
    end

    assign pos_x    = pos_q;
    assign pos_y    = 11'(POS_Y);
    assign speed    = speed_q;
    assign distance = dist_q;
    assign running  = (state_q == StRun);
    assign crashed  = (state_q == StCrash);
    assign wrapped  = wrap_q;

endmodule

// File: tb/tb_scroll_pos_gen.sv
// Directed bench for scroll_pos_gen: a fast-ramp instance (A) and a default-ramp instance (B).
module tb_scroll_pos_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, ftick_a, start_a, crash_a;
    logic [10:0] pos_x_a, pos_y_a;
    logic [3:0]  speed_a;
    logic [15:0] dist_a;
    logic        run_a, crsh_a, wrap_a;

    logic        rst_b, ftick_b, start_b, crash_b;
    logic [10:0] pos_x_b, pos_y_b;
    logic [3:0]  speed_b;
    logic [15:0] dist_b;
    logic        run_b, crsh_b, wrap_b;

    int n_cmp = 0;
    int n_err = 0;

    scroll_pos_gen #(.RAMP_FRAMES(4)) dut_a (
        .clk(clk), .rst(rst_a), .frame_tick(ftick_a), .start(start_a), .crash(crash_a),
        .pos_x(pos_x_a), .pos_y(pos_y_a), .speed(speed_a), .distance(dist_a),
        .running(run_a), .crashed(crsh_a), .wrapped(wrap_a)
    );

    scroll_pos_gen dut_b (
        .clk(clk), .rst(rst_b), .frame_tick(ftick_b), .start(start_b), .crash(crash_b),
        .pos_x(pos_x_b), .pos_y(pos_y_b), .speed(speed_b), .distance(dist_b),
        .running(run_b), .crashed(crsh_b), .wrapped(wrap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle just after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; ftick_a = 1'b0; start_a = 1'b0; crash_a = 1'b0;
        rst_b = 1'b1; ftick_b = 1'b0; start_b = 1'b0; crash_b = 1'b0;
        #3;
        chk("rst_pos",   32'(pos_x_a), 0);
        chk("rst_posy",  32'(pos_y_a), 0);
        chk("rst_speed", 32'(speed_a), 2);
        chk("rst_dist",  32'(dist_a), 0);
        chk("rst_run",   32'(run_a), 0);
        chk("rst_crash", 32'(crsh_a), 0);
        chk("rst_wrap",  32'(wrap_a), 0);
        cyc(2);
        rst_a = 1'b0; rst_b = 1'b0;
        cyc(1);

        // IDLE ignores frame_tick and crash
        ftick_a = 1'b1; crash_a = 1'b1;
        cyc(1);
        ftick_a = 1'b0; crash_a = 1'b0;
        chk("idle_pos",   32'(pos_x_a), 0);
        chk("idle_crash", 32'(crsh_a), 0);
        chk("idle_run",   32'(run_a), 0);

        // Start and first frames
        start_a = 1'b1; cyc(1); start_a = 1'b0;
        chk("start_run", 32'(run_a), 1);
        ftick_a = 1'b1; cyc(1); ftick_a = 1'b0;
        chk("t1_pos",  32'(pos_x_a), 318);
        chk("t1_wrap", 32'(wrap_a), 1);
        chk("t1_dist", 32'(dist_a), 2);
        cyc(1);
        chk("t1_wrap_clr", 32'(wrap_a), 0);
        chk("t1_pos_hold", 32'(pos_x_a), 318);
        ftick_a = 1'b1; cyc(1); ftick_a = 1'b0;
        chk("t2_pos",  32'(pos_x_a), 316);
        chk("t2_wrap", 32'(wrap_a), 0);
        chk("t2_dist", 32'(dist_a), 4);
        ftick_a = 1'b1; cyc(1); ftick_a = 1'b0;
        chk("t3_speed", 32'(speed_a), 2);
        ftick_a = 1'b1; cyc(1); ftick_a = 1'b0;
        chk("t4_pos",   32'(pos_x_a), 312);
        chk("t4_speed", 32'(speed_a), 3);
        chk("t4_dist",  32'(dist_a), 8);

        // Ramp to saturation with start held high (no effect in RUN)
        start_a = 1'b1; ftick_a = 1'b1; cyc(20);
        chk("t24_speed", 32'(speed_a), 8);
        chk("t24_pos",   32'(pos_x_a), 212);
        chk("t24_dist",  32'(dist_a), 108);
        chk("t24_run",   32'(run_a), 1);
        cyc(40); start_a = 1'b0;
        chk("t64_speed", 32'(speed_a), 8);
        chk("t64_pos",   32'(pos_x_a), 212);
        chk("t64_dist",  32'(dist_a), 428);

        // Crash beats a same-cycle tick; CRASH freezes everything
        crash_a = 1'b1; cyc(1);
        chk("crash_st",    32'(crsh_a), 1);
        chk("crash_run",   32'(run_a), 0);
        chk("crash_pos",   32'(pos_x_a), 212);
        chk("crash_dist",  32'(dist_a), 428);
        chk("crash_speed", 32'(speed_a), 8);
        cyc(3);
        ftick_a = 1'b0; crash_a = 1'b0;
        chk("frz_pos",  32'(pos_x_a), 212);
        chk("frz_dist", 32'(dist_a), 428);
        chk("frz_st",   32'(crsh_a), 1);

        // Restart from CRASH clears counters and ramp
        start_a = 1'b1; cyc(1); start_a = 1'b0;
        chk("rs_run",   32'(run_a), 1);
        chk("rs_crash", 32'(crsh_a), 0);
        chk("rs_pos",   32'(pos_x_a), 0);
        chk("rs_speed", 32'(speed_a), 2);
        chk("rs_dist",  32'(dist_a), 0);
        ftick_a = 1'b1; cyc(1);
        chk("rs_t1_pos",  32'(pos_x_a), 318);
        chk("rs_t1_wrap", 32'(wrap_a), 1);
        chk("rs_t1_dist", 32'(dist_a), 2);
        cyc(3);
        chk("rs_t4_speed", 32'(speed_a), 3);
        chk("rs_t4_pos",   32'(pos_x_a), 312);

        // Distance saturation at 16'hFFFF
        cyc(8198);
        chk("sat_pre_dist",  32'(dist_a), 65532);
        chk("sat_pre_pos",   32'(pos_x_a), 68);
        chk("sat_pre_speed", 32'(speed_a), 8);
        cyc(1);
        chk("sat_dist", 32'(dist_a), 65535);
        chk("sat_pos",  32'(pos_x_a), 60);
        cyc(1); ftick_a = 1'b0;
        chk("sat_hold_dist", 32'(dist_a), 65535);
        chk("sat_hold_pos",  32'(pos_x_a), 52);

        // Exact-hit boundary: pos_x == speed lands on 0, then pos 0 wraps
        start_b = 1'b1; cyc(1); start_b = 1'b0;
        ftick_b = 1'b1; cyc(159);
        chk("b_pre_pos",   32'(pos_x_b), 2);
        chk("b_pre_speed", 32'(speed_b), 2);
        chk("b_pre_dist",  32'(dist_b), 318);
        cyc(1);
        chk("b_zero_pos",  32'(pos_x_b), 0);
        chk("b_zero_wrap", 32'(wrap_b), 0);
        chk("b_zero_dist", 32'(dist_b), 320);
        cyc(1);
        chk("b_wrap_pos",  32'(pos_x_b), 318);
        chk("b_wrap_wrap", 32'(wrap_b), 1);
        chk("b_wrap_dist", 32'(dist_b), 322);

        // Asynchronous reset between edges, with frame_tick still high
        cyc(3);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("ar_pos",   32'(pos_x_b), 0);
        chk("ar_speed", 32'(speed_b), 2);
        chk("ar_dist",  32'(dist_b), 0);
        chk("ar_run",   32'(run_b), 0);
        chk("ar_wrap",  32'(wrap_b), 0);
        cyc(2);
        chk("ar_hold_pos", 32'(pos_x_b), 0);
        rst_b = 1'b0;
        cyc(3);
        chk("ar_idle_run",  32'(run_b), 0);
        chk("ar_idle_pos",  32'(pos_x_b), 0);
        chk("ar_idle_dist", 32'(dist_b), 0);
        ftick_b = 1'b0;
        start_b = 1'b1; cyc(1); start_b = 1'b0;
        chk("ar_start_run", 32'(run_b), 1);
        ftick_b = 1'b1; cyc(1); ftick_b = 1'b0;
        chk("ar_t1_pos", 32'(pos_x_b), 318);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scroll_pos_gen.md
Name: scroll_pos_gen

Overview:
- Per-frame scroll-offset generator for the side-scrolling background.
- Drives pos_x and pos_y of the downstream address generator.
- That generator maps screen (h_cnt, v_cnt) into a wrapped image of WIDTH x HEIGHT, so this block owns the scroll position, scroll speed, speed ramp and run/crash game state.
- It advances the offset once per frame on frame_tick, which the VGA timing block raises at the start of vertical blanking.

Parameters:
- WIDTH, 320, horizontal wrap period in pixels; must match the downstream width.
- POS_Y, 0, constant vertical offset driven on pos_y.
- SPEED_INIT, 2, scroll speed in pixels/frame after reset or restart.
- SPEED_MAX, 8, speed saturation value; requires SPEED_INIT <= SPEED_MAX < WIDTH and SPEED_MAX <= 15.
- RAMP_FRAMES, 600, number of RUN frames between +1 speed steps; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame
- start  in  1  level or pulse; starts or restarts the game
- crash  in  1  collision flag from the sprite/collision logic
- pos_x  out  11  horizontal scroll offset, range 0..WIDTH-1
- pos_y  out  11  tied to POS_Y
- speed  out  4  current scroll speed
- distance  out  16  accumulated scrolled pixels (score source), saturating
- running  out  1  high in RUN
- crashed  out  1  high in CRASH
- wrapped  out  1  one-cycle pulse when pos_x wraps

Behaviour:
- Reset: rst is asynchronous, active-high. While rst is high, and on the first clock edge after release:
  - state=IDLE, pos_x=0, speed=SPEED_INIT, ramp_cnt=0, distance=0, wrapped=0, running=0, crashed=0.
- Timing: all outputs are registered. The effect of an input sampled at edge N is visible after edge N.
- State machine, 3 states:
  - IDLE: pos, speed and distance are held. start=1 moves to RUN. frame_tick and crash are ignored.
  - RUN: the only state in which frame_tick is acted on.
    - crash=1 moves to CRASH. crash has priority over a same-cycle frame_tick, which is then dropped (no pos, speed or distance change).
    - start is ignored.
  - CRASH: all counters are frozen.
    - start=1 moves directly to RUN and, in the same edge, sets pos_x=0, speed=SPEED_INIT, ramp_cnt=0, distance=0.
    - crash and frame_tick are ignored.
- RUN frame update, on frame_tick=1 with crash=0, all using the pre-update speed:
  - Scrolling is leftward, so pos_x decreases. If pos_x >= speed: pos_x <= pos_x - speed, wrapped <= 0. Otherwise: pos_x <= pos_x + WIDTH - speed, wrapped <= 1.
  - distance <= min(distance + speed, 16'hFFFF).
  - Ramp: if ramp_cnt == RAMP_FRAMES-1, then ramp_cnt <= 0 and speed <= min(speed+1, SPEED_MAX). Otherwise ramp_cnt <= ramp_cnt+1.
  - The ramp counter keeps cycling after speed saturates.
- wrapped is 0 on every cycle without a wrapping update.
- running and crashed decode the state directly. They are never both high.
- Arithmetic:
  - pos_x math is done at 12 bits to avoid underflow. The result is always in [0, WIDTH-1].
  - ramp_cnt width is $clog2(RAMP_FRAMES)+1.
  - distance is 17-bit internally before saturation.
- Boundaries:
  - pos_x == speed gives 0 with no wrap.
  - pos_x == 0 gives WIDTH-speed with wrap.
  - A continuously high start has no effect in RUN.
  - An asynchronous reset in any state overrides everything, including mid-frame_tick.

Test Plan:
1. Reset, start=1 for 1 cycle, then frame_tick -> running=1; pos_x 0->318 with wrapped=1 for exactly 1 cycle; distance=2. Next tick -> pos_x=316, wrapped=0, distance=4.
2. RAMP_FRAMES=4 in RUN, 4 ticks -> speed 2->3 after the 4th tick; the 4th tick's move still uses 2. After 24 ticks total -> speed=8, and it stays 8 after 40 more ticks.
3. RUN with pos_x=2, speed=2, tick -> pos_x=0, wrapped=0. Next tick -> pos_x=318, wrapped=1.
4. RUN, crash=1 and frame_tick=1 on the same cycle -> crashed=1, running=0, pos_x/distance/speed unchanged. Further ticks cause no change.
5. In CRASH with pos_x=150, speed=5, distance=900, pulse start -> running=1, pos_x=0, speed=2, distance=0. The next tick gives pos_x=318.
6. Assert rst asynchronously mid-RUN, between clock edges -> outputs take their reset values immediately. frame_tick during reset has no effect. After release the block sits in IDLE until start.
